// File: rtl/dmem_waitstate.sv
// dmem_waitstate: byte-addressed 32-bit data RAM with byte/halfword/word access,
// load sign/zero extension, alignment and range checks, and a req/ready handshake
// with a configurable number of wait states between acceptance and the access.
module dmem_waitstate #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic                  DmemReq,
  input  logic                  DmemWrite,
  input  logic [1:0]            DmemSize,
  input  logic                  DmemSigned,
  input  logic [ADDR_WIDTH-1:0] DmemAddr,
  input  logic [31:0]           DmemWrData,
  output logic [31:0]           DmemRdData,
  output logic                  DmemReady,
  output logic                  DmemErr,
  output logic                  DmemBusy
);

  localparam int unsigned IdxW = $clog2(DEPTH_WORDS);
  localparam logic [ADDR_WIDTH-3:0] DepthLimit = (ADDR_WIDTH-2)'(DEPTH_WORDS);

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } state_e;

  // FSM state and wait counter
  state_e     r_state;
  state_e     w_state_nxt;
  logic [3:0] r_cnt;
  logic [3:0] w_cnt_nxt;
  logic       w_accept;
  logic       w_access;

  // Request captured at acceptance; the access uses only these copies
  logic                  r_write;
  logic [1:0]            r_size;
  logic                  r_signed;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [31:0]           r_wdata;

  // Registered response
  logic [31:0] r_rdata;
  logic        r_err;

  // Storage array (never reset)
  logic [31:0] r_mem [DEPTH_WORDS];

  // Decode of the latched request
  logic [ADDR_WIDTH-3:0] w_word_idx;
  logic [IdxW-1:0]       w_mem_idx;
  logic [1:0]            w_lane;
  logic                  w_oob;
  logic                  w_misalign;
  logic                  w_err;
  logic [31:0]           w_rd_word;
  logic [7:0]            w_rd_byte;
  logic [15:0]           w_rd_half;
  logic [31:0]           w_load;
  logic [3:0]            w_be;
  logic [31:0]           w_wr_lanes;
  logic                  w_wr_en;

  assign w_word_idx = r_addr[ADDR_WIDTH-1:2];
  assign w_mem_idx  = w_word_idx[IdxW-1:0];
  assign w_lane     = r_addr[1:0];
  assign w_oob      = (w_word_idx >= DepthLimit);

  // State register with asynchronous reset; reset during WAIT abandons the access
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state <= StIdle;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state logic: accept in IDLE, count down in WAIT, access when the count is zero
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    w_access    = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (DmemReq) begin
          w_accept    = 1'b1;
          w_cnt_nxt   = 4'(WAIT_CYCLES);
          w_state_nxt = StWait;
        end
      end
      StWait: begin
        if (r_cnt != 4'd0) begin
          w_cnt_nxt = r_cnt - 4'd1;
        end else begin
          w_access    = 1'b1;
          w_state_nxt = StResp;
        end
      end
      StResp: begin
        w_state_nxt = StIdle;
      end
      default: begin
        w_state_nxt = StIdle;
      end
    endcase
  end

  // Capture the request fields on the accepting edge
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_write  <= 1'b0;
      r_size   <= 2'b00;
      r_signed <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= 32'd0;
    end else if (w_accept) begin
      r_write  <= DmemWrite;
      r_size   <= DmemSize;
      r_signed <= DmemSigned;
      r_addr   <= DmemAddr;
      r_wdata  <= DmemWrData;
    end
  end

  // Alignment check per access size; size 11 is always rejected
  always_comb begin
    w_misalign = 1'b0;
    unique case (r_size)
      2'b00:   w_misalign = 1'b0;
      2'b01:   w_misalign = r_addr[0];
      2'b10:   w_misalign = (r_addr[1:0] != 2'b00);
      default: w_misalign = 1'b1;
    endcase
  end

  assign w_err = w_misalign | w_oob;

  // Load path: pick the addressed lane(s) and extend
  assign w_rd_word = r_mem[w_mem_idx];
  assign w_rd_byte = w_rd_word[{w_lane, 3'b000} +: 8];
  assign w_rd_half = r_addr[1] ? w_rd_word[31:16] : w_rd_word[15:0];

  // Extension of the extracted byte or halfword; word loads ignore the signed flag
  always_comb begin
    w_load = w_rd_word;
    unique case (r_size)
      2'b00:   w_load = r_signed ? {{24{w_rd_byte[7]}}, w_rd_byte} : {24'd0, w_rd_byte};
      2'b01:   w_load = r_signed ? {{16{w_rd_half[15]}}, w_rd_half} : {16'd0, w_rd_half};
      default: w_load = w_rd_word;
    endcase
  end

  // Store path: replicate right-aligned data across lanes and enable only the selected ones
  always_comb begin
    w_be       = 4'b0000;
    w_wr_lanes = r_wdata;
    unique case (r_size)
      2'b00: begin
        w_be       = 4'b0001 << w_lane;
        w_wr_lanes = {4{r_wdata[7:0]}};
      end
      2'b01: begin
        w_be       = r_addr[1] ? 4'b1100 : 4'b0011;
        w_wr_lanes = {2{r_wdata[15:0]}};
      end
      2'b10: begin
        w_be       = 4'b1111;
        w_wr_lanes = r_wdata;
      end
      default: begin
        w_be       = 4'b0000;
        w_wr_lanes = r_wdata;
      end
    endcase
  end

  assign w_wr_en = w_access & r_write & ~w_err;

  // RAM write port; no reset so contents survive Rst_n
  always_ff @(posedge Clk) begin
    if (w_wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) begin
          r_mem[w_mem_idx][8*i +: 8] <= w_wr_lanes[8*i +: 8];
        end
      end
    end
  end

  // Response registers: updated only on the access edge, held until the next one
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
    end else if (w_access) begin
      r_err   <= w_err;
      r_rdata <= (w_err || r_write) ? 32'd0 : w_load;
    end
  end

  assign DmemRdData = r_rdata;
  assign DmemErr    = r_err;
  assign DmemReady  = (r_state == StResp);
  assign DmemBusy   = (r_state != StIdle);

endmodule

// File: tb/tb_dmem_waitstate.sv
// Scoreboard bench for dmem_waitstate: a byte-array reference model predicts every
// response at issue time, and an independent monitor checks each DmemReady pulse.
module tb_dmem_waitstate;

  localparam int unsigned AW    = 32;
  localparam int unsigned DEPTH = 256;
  localparam int unsigned WS    = 2;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic        DmemReq = 1'b0;
  logic        DmemWrite = 1'b0;
  logic [1:0]  DmemSize = 2'b00;
  logic        DmemSigned = 1'b0;
  logic [31:0] DmemAddr = 32'd0;
  logic [31:0] DmemWrData = 32'd0;
  logic [31:0] DmemRdData;
  logic        DmemReady, DmemErr, DmemBusy;

  // Second instance with no wait states
  logic        z_req = 1'b0;
  logic        z_write = 1'b0;
  logic [1:0]  z_size = 2'b10;
  logic        z_signed = 1'b0;
  logic [31:0] z_addr = 32'd0;
  logic [31:0] z_wdata = 32'd0;
  logic [31:0] z_rdata;
  logic        z_ready, z_err, z_busy;

  dmem_waitstate #(.ADDR_WIDTH(AW), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WS)) u_dut (
    .Clk(Clk), .Rst_n(Rst_n), .DmemReq(DmemReq), .DmemWrite(DmemWrite),
    .DmemSize(DmemSize), .DmemSigned(DmemSigned), .DmemAddr(DmemAddr),
    .DmemWrData(DmemWrData), .DmemRdData(DmemRdData), .DmemReady(DmemReady),
    .DmemErr(DmemErr), .DmemBusy(DmemBusy)
  );

  dmem_waitstate #(.ADDR_WIDTH(AW), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) u_dut_w0 (
    .Clk(Clk), .Rst_n(Rst_n), .DmemReq(z_req), .DmemWrite(z_write),
    .DmemSize(z_size), .DmemSigned(z_signed), .DmemAddr(z_addr),
    .DmemWrData(z_wdata), .DmemRdData(z_rdata), .DmemReady(z_ready),
    .DmemErr(z_err), .DmemBusy(z_busy)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          exp_cyc;
  } exp_t;

  exp_t sb[$];

  logic [7:0] mem_m [4*DEPTH];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: memory as a flat byte array, accesses as byte loops
  task automatic model_access(input bit wr, input logic [1:0] sz, input bit sg,
                              input logic [31:0] a, input logic [31:0] wd,
                              output logic [31:0] rd, output bit er);
    int nbytes;
    logic [31:0] w;
    er = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0) ||
         ((a / 4) >= DEPTH);
    rd = 32'd0;
    if (er) return;
    nbytes = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    if (wr) begin
      for (int i = 0; i < nbytes; i++) mem_m[a + i] = wd[8*i +: 8];
    end else begin
      w = 32'd0;
      for (int i = 0; i < nbytes; i++) w[8*i +: 8] = mem_m[a + i];
      if (nbytes < 4 && sg && w[8*nbytes-1]) begin
        for (int i = nbytes; i < 4; i++) w[8*i +: 8] = 8'hFF;
      end
      rd = w;
    end
  endtask

  // Issue one request from a negedge with the DUT idle; optionally pester with
  // ignored requests while it is busy. Returns at a negedge with the DUT idle.
  task automatic issue(input bit wr, input logic [1:0] sz, input bit sg,
                       input logic [31:0] a, input logic [31:0] wd, input bit pester);
    logic [31:0] rd;
    bit er;
    bit idle;
    exp_t e;
    model_access(wr, sz, sg, a, wd, rd, er);
    e.rdata   = rd;
    e.err     = er;
    e.exp_cyc = cyc + 1 + WS + 1;
    sb.push_back(e);
    DmemReq = 1'b1; DmemWrite = wr; DmemSize = sz; DmemSigned = sg;
    DmemAddr = a; DmemWrData = wd;
    @(negedge Clk);
    DmemReq = 1'b0;
    chk("busy_after_accept", 32'(DmemBusy), 32'd1);
    idle = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (!DmemBusy) begin
        idle = 1'b1;
        break;
      end
      if (pester) begin
        DmemReq    = 1'($urandom_range(0, 1));
        DmemWrite  = 1'($urandom_range(0, 1));
        DmemSize   = 2'($urandom_range(0, 3));
        DmemAddr   = {22'd0, 10'($urandom_range(0, 1023))};
        DmemWrData = $urandom();
      end
      @(negedge Clk);
    end
    DmemReq = 1'b0;
    if (!idle) chk("idle_timeout", 32'd0, 32'd1);
  endtask

  // Monitor: every ready pulse must match the oldest prediction
  logic prev_ready = 1'b0;
  always @(negedge Clk) begin
    if (Rst_n && DmemReady) begin
      chk("ready_gap", 32'(prev_ready), 32'd0);
      chk("busy_in_resp", 32'(DmemBusy), 32'd1);
      if (sb.size() == 0) begin
        chk("unexpected_ready", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("rdata", DmemRdData, e.rdata);
        chk("err", 32'(DmemErr), 32'(e.err));
        chk("latency", 32'(cyc), 32'(e.exp_cyc));
      end
    end
    prev_ready <= DmemReady && Rst_n;
  end

  // Access on the zero-wait instance; checks latency and response directly
  task automatic z_access(input bit wr, input logic [1:0] sz, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] exp_rd,
                          input bit exp_err);
    int e0;
    bit found;
    z_req = 1'b1; z_write = wr; z_size = sz; z_signed = 1'b0; z_addr = a; z_wdata = wd;
    e0 = cyc + 1;
    @(negedge Clk);
    z_req = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (z_ready) begin
        found = 1'b1;
        break;
      end
      @(negedge Clk);
    end
    chk("w0_ready_seen", 32'(found), 32'd1);
    if (found) begin
      chk("w0_latency", 32'(cyc), 32'(e0 + 1));
      chk("w0_rdata", z_rdata, exp_rd);
      chk("w0_err", 32'(z_err), 32'(exp_err));
    end
    @(negedge Clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    chk("rst_ready", 32'(DmemReady), 32'd0);
    chk("rst_busy", 32'(DmemBusy), 32'd0);
    chk("rst_err", 32'(DmemErr), 32'd0);
    chk("rst_rdata", DmemRdData, 32'd0);
    repeat (2) @(negedge Clk);
    Rst_n = 1'b1;
    @(negedge Clk);

    // Fill the whole array so every later load reads known data
    for (int i = 0; i < int'(DEPTH); i++) issue(1'b1, 2'd2, 1'b0, 32'(4 * i), $urandom(), 1'b0);

    // Word round trip
    issue(1'b1, 2'd2, 1'b0, 32'h10, 32'h12345678, 1'b0);
    issue(1'b0, 2'd2, 1'b0, 32'h10, 32'd0, 1'b0);
    // Byte lanes
    issue(1'b1, 2'd0, 1'b0, 32'h11, 32'hFFFF_FFAB, 1'b0);
    issue(1'b0, 2'd2, 1'b0, 32'h10, 32'd0, 1'b0);
    issue(1'b0, 2'd0, 1'b1, 32'h11, 32'd0, 1'b0);
    issue(1'b0, 2'd0, 1'b0, 32'h11, 32'd0, 1'b0);
    // Halfword
    issue(1'b0, 2'd1, 1'b1, 32'h12, 32'd0, 1'b0);
    issue(1'b1, 2'd1, 1'b0, 32'h12, 32'h0000_8001, 1'b0);
    issue(1'b0, 2'd1, 1'b1, 32'h12, 32'd0, 1'b0);
    issue(1'b0, 2'd1, 1'b0, 32'h12, 32'd0, 1'b0);
    issue(1'b0, 2'd2, 1'b0, 32'h10, 32'd0, 1'b0);
    // Errors
    issue(1'b0, 2'd2, 1'b0, 32'h12, 32'd0, 1'b0);
    issue(1'b1, 2'd1, 1'b0, 32'h13, 32'h5555, 1'b0);
    issue(1'b0, 2'd3, 1'b0, 32'h10, 32'd0, 1'b0);
    issue(1'b1, 2'd3, 1'b0, 32'h10, 32'hFFFF_FFFF, 1'b0);
    issue(1'b0, 2'd2, 1'b0, 32'(4 * DEPTH), 32'd0, 1'b0);
    issue(1'b1, 2'd2, 1'b0, 32'(4 * DEPTH), 32'h1111_2222, 1'b0);
    issue(1'b0, 2'd2, 1'b0, 32'h10, 32'd0, 1'b0);
    // Handshake: requests during WAIT/RESP are ignored
    for (int i = 0; i < 8; i++) issue(1'b0, 2'd2, 1'b0, 32'h10, 32'd0, 1'b1);

    // Reset during WAIT aborts a store; last response was a nonzero load
    DmemReq = 1'b1; DmemWrite = 1'b1; DmemSize = 2'd2; DmemSigned = 1'b0;
    DmemAddr = 32'h10; DmemWrData = 32'hDEADBEEF;
    @(negedge Clk);
    DmemReq = 1'b0;
    #2 Rst_n = 1'b0;
    #1;
    chk("arst_ready", 32'(DmemReady), 32'd0);
    chk("arst_busy", 32'(DmemBusy), 32'd0);
    chk("arst_rdata", DmemRdData, 32'd0);
    chk("arst_err", 32'(DmemErr), 32'd0);
    repeat (3) @(negedge Clk);
    Rst_n = 1'b1;
    @(negedge Clk);
    issue(1'b0, 2'd2, 1'b0, 32'h10, 32'd0, 1'b0);

    // Zero wait states
    z_access(1'b1, 2'd2, 32'h20, 32'hCAFE_F00D, 32'd0, 1'b0);
    z_access(1'b0, 2'd2, 32'h20, 32'd0, 32'hCAFE_F00D, 1'b0);
    z_access(1'b0, 2'd1, 32'h21, 32'd0, 32'd0, 1'b1);

    // Randomized traffic
    for (int n = 0; n < 200; n++) begin
      logic [1:0] sz;
      logic [31:0] a;
      int lane;
      sz = ($urandom_range(0, 19) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      lane = $urandom_range(0, 3);
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'd1) lane = lane & 2;
        if (sz == 2'd2) lane = 0;
      end
      a = 32'(4 * $urandom_range(0, DEPTH - 1) + lane);
      if ($urandom_range(0, 9) == 0) a = $urandom() | 32'h0000_0400;
      issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom(),
            1'($urandom_range(0, 1)));
    end

    repeat (10) @(negedge Clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dmem_waitstate.md
Name: dmem_waitstate

Overview:
- Parametrised successor to the single-cycle data memory.
- Byte-addressed 32-bit data RAM with byte, halfword and word accesses, signed or unsigned load extension, and alignment and range checking.
- Uses a req/ready handshake with a configurable number of wait states, so the multi-cycle and pipelined cores can model slower memory.
- Sits between the core's MEM stage and the RAM array.

Parameters:
- ADDR_WIDTH, 32, width of DmemAddr (byte address).
- DEPTH_WORDS, 256, number of 32-bit words in the array; must be a power of two, at least 4.
- WAIT_CYCLES, 2, extra cycles between acceptance and the memory access; range 0..15.

Ports:
- Clk  in  1  clock; all state changes on the rising edge.
- Rst_n  in  1  asynchronous active-low reset.
- DmemReq  in  1  request strobe; sampled only in IDLE.
- DmemWrite  in  1  1 = store, 0 = load; sampled with DmemReq.
- DmemSize  in  2  00 byte, 01 halfword, 10 word; 11 is treated as an error.
- DmemSigned  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- DmemAddr  in  ADDR_WIDTH  byte address.
- DmemWrData  in  32  store data, right-aligned (byte in [7:0], halfword in [15:0]).
- DmemRdData  out  32  load result, extended.
- DmemReady  out  1  one-cycle completion pulse.
- DmemErr  out  1  valid with DmemReady; 1 = access rejected.
- DmemBusy  out  1  high while state != IDLE.

Behaviour:
- Reset is asynchronous on Rst_n low:
  - State goes to IDLE; wait counter clears.
  - DmemReady=0, DmemErr=0, DmemRdData=0, DmemBusy=0.
  - RAM contents are not cleared.
  - Reset during WAIT aborts the access and any pending store is not performed.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - On an edge with DmemReq=1, latch Write, Size, Signed, Addr and WrData.
  - Load counter with WAIT_CYCLES and go to WAIT.
  - DmemReq=0 keeps the FSM in IDLE.
- WAIT:
  - While counter != 0, decrement the counter each edge.
  - On the edge where counter == 0, perform the access using the latched values, register the outputs, and go to RESP.
- RESP:
  - DmemReady=1 for exactly this cycle, then return to IDLE on the next edge.
- Latency: DmemReady is high in the cycle after edge E0+WAIT_CYCLES+1, where E0 is the accepting edge. Minimum request-to-request spacing is WAIT_CYCLES+3 cycles.
- DmemReq during WAIT or RESP is ignored; it is not queued.
- Word index is Addr[ADDR_WIDTH-1:2]; the byte lane is Addr[1:0].
- Error conditions:
  - Size=11.
  - Halfword with Addr[0]=1.
  - Word with Addr[1:0]!=0.
  - Word index >= DEPTH_WORDS.
- On error: no RAM write, DmemErr=1, DmemRdData=0, same latency as a normal access.
- Store:
  - Byte: WrData[7:0] goes to lane Addr[1:0].
  - Halfword: WrData[15:0] goes to lanes {Addr[1],1} and {Addr[1],0}.
  - Word: all four lanes are written.
  - Unselected lanes are unchanged. Little-endian: lane 0 = bits [7:0].
  - DmemRdData is driven to 0 on a store response.
- Load: extract the selected byte or halfword and extend it per the latched Signed. A word load ignores Signed.
- DmemRdData and DmemErr hold their values until the next RESP or a reset.
- DmemReady is never high in two consecutive cycles.

Test Plan:
1. Word round trip (WAIT_CYCLES=2): store word 0x12345678 to 0x10, then load word from 0x10.
   - Each DmemReady pulse occurs 3 edges after acceptance.
   - DmemRdData=0x12345678, DmemErr=0, DmemBusy high from acceptance through RESP.
2. Byte lanes: after scenario 1, store byte 0xAB to 0x11.
   - Word load from 0x10 returns 0x1234AB78.
   - Signed byte load from 0x11 returns 0xFFFFFFAB; unsigned returns 0x000000AB.
3. Halfword:
   - Signed halfword load from 0x12 returns 0x00001234.
   - Store halfword 0x8001 to 0x12; signed load returns 0xFFFF8001, unsigned returns 0x00008001.
   - Word load from 0x10 returns 0x8001AB78.
4. Errors:
   - Word load from 0x12, halfword store to 0x13, Size=11, and word access at 4*DEPTH_WORDS each give DmemErr=1 with DmemRdData=0.
   - A following word load from 0x10 still returns 0x8001AB78.
5. Handshake: pulse DmemReq during WAIT and during RESP.
   - There is exactly one DmemReady per accepted request.
   - The ignored requests cause no RAM change.
   - With WAIT_CYCLES=0, DmemReady is high in the cycle after edge E0+1.
6. Reset mid-operation: start a store of 0xDEADBEEF to 0x10, then drop Rst_n during WAIT.
   - Outputs go to 0 immediately (asynchronously) and no DmemReady pulse occurs.
   - After release, a word load from 0x10 returns 0x8001AB78.
